// File: rtl/img_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : img_stream_gen
//  Brief    : Video stream source. Generates the pre_img_* stream from
//             H/V timing counters with three built-in test patterns or an
//             external pixel memory read through a 1-cycle read port.
//  Revision : 1.0  initial release
// ============================================================================
module img_stream_gen #(
    parameter int          DATA_WIDTH = 8,
    parameter logic [10:0] H_SYNC     = 11'd40,
    parameter logic [10:0] H_BACK     = 11'd220,
    parameter logic [10:0] H_DISP     = 11'd1280,
    parameter logic [10:0] H_FRONT    = 11'd110,
    parameter logic [10:0] H_TOTAL    = 11'd1650,
    parameter logic [10:0] V_SYNC     = 11'd5,
    parameter logic [10:0] V_BACK     = 11'd20,
    parameter logic [10:0] V_DISP     = 11'd720,
    parameter logic [10:0] V_FRONT    = 11'd5,
    parameter logic [10:0] V_TOTAL    = 11'd750
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            pattern_sel,
    output logic                  pix_req,
    output logic [10:0]           pix_x,
    output logic [10:0]           pix_y,
    input  logic [DATA_WIDTH-1:0] pix_rd_data,
    output logic                  pre_img_vsync,
    output logic                  pre_img_hsync,
    output logic                  pre_img_valid,
    output logic [DATA_WIDTH-1:0] pre_img_data,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt
);

    // Active-region bounds in counter coordinates.
    localparam logic [10:0] c_H_ACT_START = H_SYNC + H_BACK;
    localparam logic [10:0] c_H_ACT_END   = c_H_ACT_START + H_DISP;
    localparam logic [10:0] c_V_ACT_START = V_SYNC + V_BACK;
    localparam logic [10:0] c_V_ACT_END   = c_V_ACT_START + V_DISP;
    // The period is the larger of the declared total and the segment sum, so a
    // stretched total only lengthens the front porch and an undersized total
    // can never cut into the active region.
    localparam logic [10:0] c_H_SUM  = c_H_ACT_END + H_FRONT;
    localparam logic [10:0] c_V_SUM  = c_V_ACT_END + V_FRONT;
    localparam logic [10:0] c_H_LAST = ((H_TOTAL > c_H_SUM) ? H_TOTAL : c_H_SUM) - 11'd1;
    localparam logic [10:0] c_V_LAST = ((V_TOTAL > c_V_SUM) ? V_TOTAL : c_V_SUM) - 11'd1;
    localparam logic [1:0]  c_SEL_EXT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [10:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic [1:0]  r_sel_q;

    logic        w_running;
    logic        w_frame_first;
    logic        w_frame_last;
    logic        w_hs;
    logic        w_vs;
    logic        w_act;
    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [1:0]  w_sel_eff;

    logic                  r_s1_hs;
    logic                  r_s1_vs;
    logic                  r_s1_act;
    logic [10:0]           r_s1_x;
    logic [10:0]           r_s1_y;
    logic [1:0]            r_s1_sel;
    logic                  r_s1_last;
    logic [DATA_WIDTH-1:0] w_pat;
    logic [DATA_WIDTH-1:0] r_s2_data;
    logic                  r_s2_ext;
    logic                  r_s2_last;

    // Stage-0 decode; everything is forced low outside RUN/DRAIN because the
    // idle counters (0,0) would otherwise decode as sync.
    assign w_running     = (r_state != ST_IDLE);
    assign w_frame_first = w_running && (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
    assign w_frame_last  = w_running && (r_h_cnt == c_H_LAST) && (r_v_cnt == c_V_LAST);
    assign w_hs          = w_running && (r_h_cnt < H_SYNC);
    assign w_vs          = w_running && (r_v_cnt < V_SYNC);
    assign w_act         = w_running
                         && (r_h_cnt >= c_H_ACT_START) && (r_h_cnt < c_H_ACT_END)
                         && (r_v_cnt >= c_V_ACT_START) && (r_v_cnt < c_V_ACT_END);
    assign w_x           = r_h_cnt - c_H_ACT_START;
    assign w_y           = r_v_cnt - c_V_ACT_START;
    // On the first frame cycle the new selection is already in force.
    assign w_sel_eff     = w_frame_first ? pattern_sel : r_sel_q;

    // Run-state machine, H/V counters and per-frame pattern latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_h_cnt <= 11'd0;
            r_v_cnt <= 11'd0;
            r_sel_q <= 2'd0;
        end else begin
            if (w_frame_first) begin
                r_sel_q <= pattern_sel;
            end
            case (r_state)
                ST_IDLE: begin
                    r_h_cnt <= 11'd0;
                    r_v_cnt <= 11'd0;
                    if (enable) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN, ST_DRAIN: begin
                    if (w_frame_last) begin
                        r_h_cnt <= 11'd0;
                        r_v_cnt <= 11'd0;
                        r_state <= enable ? ST_RUN : ST_IDLE;
                    end else begin
                        if (r_h_cnt == c_H_LAST) begin
                            r_h_cnt <= 11'd0;
                            r_v_cnt <= r_v_cnt + 11'd1;
                        end else begin
                            r_h_cnt <= r_h_cnt + 11'd1;
                        end
                        r_state <= enable ? ST_RUN : ST_DRAIN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_h_cnt <= 11'd0;
                    r_v_cnt <= 11'd0;
                end
            endcase
        end
    end

    // Stage 1: delayed decode plus the external read request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_hs   <= 1'b0;
            r_s1_vs   <= 1'b0;
            r_s1_act  <= 1'b0;
            r_s1_x    <= 11'd0;
            r_s1_y    <= 11'd0;
            r_s1_sel  <= 2'd0;
            r_s1_last <= 1'b0;
            pix_req   <= 1'b0;
            pix_x     <= 11'd0;
            pix_y     <= 11'd0;
        end else begin
            r_s1_hs   <= w_hs;
            r_s1_vs   <= w_vs;
            r_s1_act  <= w_act;
            r_s1_x    <= w_act ? w_x : 11'd0;
            r_s1_y    <= w_act ? w_y : 11'd0;
            r_s1_sel  <= w_sel_eff;
            r_s1_last <= w_frame_last;
            pix_req   <= w_act && (w_sel_eff == c_SEL_EXT);
            pix_x     <= (w_act && (w_sel_eff == c_SEL_EXT)) ? w_x : 11'd0;
            pix_y     <= (w_act && (w_sel_eff == c_SEL_EXT)) ? w_y : 11'd0;
        end
    end

    // Built-in pattern value for the stage-1 coordinate.
    always_comb begin
        w_pat = '0;
        case (r_s1_sel)
            2'd0:    w_pat = DATA_WIDTH'(r_s1_x);
            2'd1:    w_pat = DATA_WIDTH'(r_s1_y);
            2'd2:    w_pat = (r_s1_x[3] ^ r_s1_y[3]) ? '1 : '0;
            default: w_pat = '0;
        endcase
    end

    // Stage 2: stream outputs and end-of-frame tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_img_vsync <= 1'b0;
            pre_img_hsync <= 1'b0;
            pre_img_valid <= 1'b0;
            r_s2_data     <= '0;
            r_s2_ext      <= 1'b0;
            r_s2_last     <= 1'b0;
        end else begin
            pre_img_vsync <= r_s1_vs;
            pre_img_hsync <= r_s1_hs;
            pre_img_valid <= r_s1_act;
            r_s2_data     <= r_s1_act ? w_pat : '0;
            r_s2_ext      <= r_s1_act && (r_s1_sel == c_SEL_EXT);
            r_s2_last     <= r_s1_last;
        end
    end

    // The external memory's own output register is the stage-2 register for
    // pattern 3: its data arrives in the cycle the pixel is presented.
    assign pre_img_data = r_s2_ext ? pix_rd_data : r_s2_data;

    // Frame completion pulse and counter, one cycle after the last output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
        end else begin
            frame_done <= r_s2_last;
            if (r_s2_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_img_stream_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_img_stream_gen
//  Brief    : Directed self-checking bench for img_stream_gen on a reduced
//             23x8 timing (H 2/3/16/2, V 1/2/4/1).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_img_stream_gen;

    localparam int HT = 23;
    localparam int FT = 184;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        pix_req;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic [7:0]  pix_rd_data;
    logic        pre_img_vsync;
    logic        pre_img_hsync;
    logic        pre_img_valid;
    logic [7:0]  pre_img_data;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int n;
    int k_end;
    int fc_base;
    int sel_f [8];
    int n_valid;
    int n_hs;
    int n_vs;

    img_stream_gen #(
        .DATA_WIDTH (8),
        .H_SYNC (11'd2), .H_BACK (11'd3), .H_DISP (11'd16), .H_FRONT (11'd2), .H_TOTAL (11'd23),
        .V_SYNC (11'd1), .V_BACK (11'd2), .V_DISP (11'd4),  .V_FRONT (11'd1), .V_TOTAL (11'd8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pattern_sel   (pattern_sel),
        .pix_req       (pix_req),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_rd_data   (pix_rd_data),
        .pre_img_vsync (pre_img_vsync),
        .pre_img_hsync (pre_img_hsync),
        .pre_img_valid (pre_img_valid),
        .pre_img_data  (pre_img_data),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    // Pixel memory: returns x + 16*y one cycle after the request.
    always @(posedge clk) begin
        pix_rd_data <= pix_req ? 8'(pix_x + (pix_y << 4)) : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stage-0 view of counter state k of the current run.
    task automatic decode(input int k, output bit hs, output bit vs, output bit act,
                          output int x, output int y, output int pix, output int sel);
        int kk, h, v;
        hs = 0; vs = 0; act = 0; x = 0; y = 0; pix = 0; sel = 0;
        if (k < 0 || k >= k_end) return;
        sel = sel_f[(k / FT) % 8];
        kk  = k % FT;
        h   = kk % HT;
        v   = kk / HT;
        hs  = (h < 2);
        vs  = (v < 1);
        act = (h >= 5) && (h < 21) && (v >= 3) && (v < 7);
        if (act) begin
            x = h - 5;
            y = v - 3;
            case (sel)
                0:       pix = x;
                1:       pix = y;
                2:       pix = (((x >> 3) ^ (y >> 3)) & 1) ? 255 : 0;
                default: pix = (x + 16 * y) & 255;
            endcase
        end
    endtask

    task automatic check_cycle();
        bit hs, vs, act, hs1, vs1, act1, rq, fd;
        int x, y, pix, sel, x1, y1, pix1, sel1, m, kmax;
        decode(n - 2, hs, vs, act, x, y, pix, sel);
        chk("vsync", pre_img_vsync, vs);
        chk("hsync", pre_img_hsync, hs);
        chk("valid", pre_img_valid, act);
        chk("data",  pre_img_data,  pix);
        decode(n - 1, hs1, vs1, act1, x1, y1, pix1, sel1);
        rq = act1 && (sel1 == 3);
        chk("pix_req", pix_req, rq);
        chk("pix_x", pix_x, rq ? x1 : 0);
        chk("pix_y", pix_y, rq ? y1 : 0);
        kmax = k_end / FT;
        m  = 0;
        fd = 0;
        if (n >= FT + 2) begin
            m  = (n - FT - 2) / FT + 1;
            if (m > kmax) m = kmax;
            fd = (((n - FT - 2) % FT) == 0) && (((n - FT - 2) / FT) < kmax);
        end
        chk("frame_done", frame_done, fd);
        chk("frame_cnt", frame_cnt, fc_base + m);
        n_valid += int'(pre_img_valid);
        n_hs    += int'(pre_img_hsync);
        n_vs    += int'(pre_img_vsync);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        tick();
        n = 0;
        check_cycle();
    endtask

    task automatic run_to(input int t);
        while (n < t) begin
            tick();
            n++;
            check_cycle();
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vsync"}, pre_img_vsync, 0);
        chk({tag, "_hsync"}, pre_img_hsync, 0);
        chk({tag, "_valid"}, pre_img_valid, 0);
        chk({tag, "_data"},  pre_img_data,  0);
        chk({tag, "_req"},   pix_req,       0);
        chk({tag, "_x"},     pix_x,         0);
        chk({tag, "_y"},     pix_y,         0);
        chk({tag, "_done"},  frame_done,    0);
        chk({tag, "_cnt"},   frame_cnt,     0);
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        n_valid = 0; n_hs = 0; n_vs = 0;
        for (int i = 0; i < 8; i++) sel_f[i] = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_all_zero("reset");

        // Five back-to-back frames: 0, 0, 1, 2, 3; enable drops in frame 4.
        sel_f[2] = 1; sel_f[3] = 2; sel_f[4] = 3;
        k_end   = 5 * FT;
        fc_base = 0;
        enable  = 1'b1;
        start_run();
        run_to(75);
        chk("p0_before_first_valid", pre_img_valid, 0);
        run_to(76);
        chk("p0_first_valid", pre_img_valid, 1);
        chk("p0_first_data", pre_img_data, 8'd0);
        run_to(91);
        chk("p0_last_data", pre_img_data, 8'd15);
        run_to(276);
        pattern_sel = 2'd1;
        run_to(460);
        pattern_sel = 2'd2;
        run_to(467);
        chk("p1_row1_data", pre_img_data, 8'd1);
        run_to(635);
        chk("p2_x7_data", pre_img_data, 8'h00);
        run_to(636);
        chk("p2_x8_data", pre_img_data, 8'hFF);
        run_to(644);
        pattern_sel = 2'd3;
        run_to(828);
        enable = 1'b0;
        run_to(858);
        chk("p3_row2_first", pre_img_data, 8'd32);
        run_to(960);
        chk("valid_total", n_valid, 5 * 64);
        chk("hsync_total", n_hs, 5 * 8 * 2);
        chk("vsync_total", n_vs, 5 * HT);
        chk("drain_frame_cnt", frame_cnt, 16'd5);

        // Restart, drop enable mid-frame and bring it back during the drain.
        pattern_sel = 2'd0;
        for (int i = 0; i < 8; i++) sel_f[i] = 0;
        k_end   = 1 << 20;
        fc_base = 5;
        enable  = 1'b1;
        start_run();
        run_to(92);
        enable = 1'b0;
        run_to(120);
        enable = 1'b1;
        run_to(447);
        chk("pre_reset_valid", pre_img_valid, 1);
        chk("pre_reset_cnt", frame_cnt, 16'd7);

        // One-cycle reset mid-line with enable held high.
        rst_n = 1'b0;
        tick();
        check_all_zero("midreset");
        rst_n   = 1'b1;
        fc_base = 0;
        start_run();
        run_to(76);
        chk("restart_first_valid", pre_img_valid, 1);
        chk("restart_first_data", pre_img_data, 8'd0);
        run_to(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
